// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer and its Shifter stage.
// Op-code and FSM state encodings.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        LEFT2 = 2'b00,
        LEFT4 = 2'b01,
        RIGHT = 2'b10,
        NOP   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Combinational shifter stage: <<1, <<2 or logical >>1, truncated to size bits.
// Code 11 passes the operand through unchanged.
module Shifter #(
    parameter int size = 5
) (
    input  logic [size-1:0] data,
    input  logic [1:0]      coefficient,
    output logic [size-1:0] shifted
);

    always_comb begin
        unique case (coefficient)
            2'b00:   shifted = data << 1;
            2'b01:   shifted = data << 2;
            2'b10:   shifted = data >> 1;
            default: shifted = data;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Runs a captured program of shift ops over an operand, one per clock,
// optionally accumulating each intermediate result.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int SIZE  = 5,
    parameter int STEPS = 4,
    parameter int ACC_W = 8,
    parameter int CNT_W = $clog2(STEPS) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SIZE-1:0]    data,
    input  logic [2*STEPS-1:0] ops,
    input  logic [STEPS-1:0]   add_mask,
    input  logic [CNT_W-1:0]   num_steps,
    output logic               busy,
    output logic               done,
    output logic [SIZE-1:0]    value,
    output logic [ACC_W-1:0]   acc
);

    localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_e             state_q, state_d;
    logic [SIZE-1:0]    value_q, value_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]   nsteps_q, nsteps_d;
    logic [2*STEPS-1:0] ops_q, ops_d;
    logic [STEPS-1:0]   mask_q, mask_d;

    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   n_clamp;
    op_e                op;
    logic [1:0]         coef;
    logic [SIZE-1:0]    shifted;
    logic [SIZE-1:0]    result;

    assign idx     = step_q[IDX_W-1:0];
    assign op      = op_e'(ops_q[{idx, 1'b1}-:2]);
    assign n_clamp = (num_steps > CNT_W'(STEPS)) ? CNT_W'(STEPS) : num_steps;

    // NOP never reaches the shifter; the held operand is selected here instead
    assign coef   = (op == NOP) ? LEFT2 : op;
    assign result = (op == NOP) ? value_q : shifted;

    Shifter #(
        .size(SIZE)
    ) u_shifter (
        .data       (value_q),
        .coefficient(coef),
        .shifted    (shifted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            value_q  <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            nsteps_q <= '0;
            ops_q    <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            nsteps_q <= nsteps_d;
            ops_q    <= ops_d;
            mask_q   <= mask_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        acc_d    = acc_q;
        step_d   = step_q;
        nsteps_d = nsteps_q;
        ops_d    = ops_q;
        mask_d   = mask_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    value_d  = data;
                    acc_d    = '0;
                    step_d   = '0;
                    ops_d    = ops;
                    mask_d   = add_mask;
                    nsteps_d = n_clamp;
                    state_d  = (n_clamp != '0) ? BUSY : DONE;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                value_d = result;
                if (mask_q[idx]) acc_d = acc_q + ACC_W'(result);
                step_d = step_q + CNT_W'(1);
                if (step_q == nsteps_q - CNT_W'(1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q == BUSY);
    assign done  = (state_q == DONE);
    assign value = value_q;
    assign acc   = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: two instances sharing stimulus,
// one with an 8-bit and one with a 6-bit accumulator.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] data = '0;
    logic [7:0] ops = '0;
    logic [3:0] mask = '0;
    logic [2:0] nsteps = '0;

    logic       busy, done, busy6, done6;
    logic [4:0] value, value6;
    logic [7:0] acc;
    logic [5:0] acc6;

    int total = 0;
    int passed = 0;

    shift_sequencer #(.SIZE(5), .STEPS(4), .ACC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data),
        .ops(ops), .add_mask(mask), .num_steps(nsteps),
        .busy(busy), .done(done), .value(value), .acc(acc)
    );

    shift_sequencer #(.SIZE(5), .STEPS(4), .ACC_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data),
        .ops(ops), .add_mask(mask), .num_steps(nsteps),
        .busy(busy6), .done(done6), .value(value6), .acc(acc6)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive a job request; returns just after the edge that loads it.
    task automatic launch(input logic [4:0] d, input logic [7:0] o,
                          input logic [3:0] m, input logic [2:0] n);
        data = d; ops = o; mask = m; nsteps = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        total++;
        if ({busy, done, value, acc} !== 15'd0)
            $display("FAIL reset busy=%b done=%b value=%0d acc=%0d want 0,0,0,0",
                     busy, done, value, acc);
        else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({busy, done, value, acc} !== 15'd0)
            $display("FAIL reset_idle busy=%b done=%b value=%0d acc=%0d want 0,0,0,0",
                     busy, done, value, acc);
        else passed++;
    endtask

    task automatic test_basic;
        int ev[3] = '{6, 24, 12};
        int ea[3] = '{6, 30, 42};
        launch(5'd3, 8'b11_10_01_00, 4'b0111, 3'd3);
        total++;
        if ({busy, done, value, acc} !== {1'b1, 1'b0, 5'd3, 8'd0})
            $display("FAIL basic_load busy=%b done=%b value=%0d acc=%0d want 1,0,3,0",
                     busy, done, value, acc);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (value !== 5'(ev[i]) || acc !== 8'(ea[i])
                || done !== (i == 2) || busy !== (i != 2))
                $display("FAIL basic_step%0d value=%0d acc=%0d done=%b busy=%b want %0d,%0d,%b,%b",
                         i, value, acc, done, busy, ev[i], ea[i], i == 2, i != 2);
            else passed++;
        end
        tick();
        total++;
        if ({busy, done, value, acc} !== {1'b0, 1'b0, 5'd12, 8'd42})
            $display("FAIL basic_hold busy=%b done=%b value=%0d acc=%0d want 0,0,12,42",
                     busy, done, value, acc);
        else passed++;
    endtask

    task automatic test_truncate;
        launch(5'b10001, 8'b11_11_11_00, 4'b0000, 3'd1);
        tick();
        total++;
        if (value !== 5'd2 || acc !== 8'd0 || done !== 1'b1)
            $display("FAIL trunc value=%0d acc=%0d done=%b want 2,0,1", value, acc, done);
        else passed++;
        tick();
    endtask

    task automatic test_wrap;
        int ev[4] = '{30, 28, 24, 16};
        launch(5'd31, 8'b00_00_00_00, 4'b1111, 3'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (value !== 5'(ev[i]) || value6 !== 5'(ev[i]))
                $display("FAIL wrap_step%0d value=%0d value6=%0d want %0d",
                         i, value, value6, ev[i]);
            else passed++;
        end
        total++;
        if (acc6 !== 6'd34 || acc !== 8'd98 || done6 !== 1'b1)
            $display("FAIL wrap_acc acc6=%0d acc8=%0d done6=%b want 34,98,1",
                     acc6, acc, done6);
        else passed++;
        tick();
    endtask

    task automatic test_nop_zero;
        launch(5'd9, 8'b00_00_00_11, 4'b0001, 3'd1);
        tick();
        total++;
        if (value !== 5'd9 || acc !== 8'd9 || done !== 1'b1)
            $display("FAIL nop value=%0d acc=%0d done=%b want 9,9,1", value, acc, done);
        else passed++;
        tick();
        launch(5'd7, 8'b00_00_00_00, 4'b1111, 3'd0);
        total++;
        if ({busy, done, value, acc} !== {1'b0, 1'b1, 5'd7, 8'd0})
            $display("FAIL zero_len busy=%b done=%b value=%0d acc=%0d want 0,1,7,0",
                     busy, done, value, acc);
        else passed++;
        tick();
        total++;
        if (done !== 1'b0 || value !== 5'd7)
            $display("FAIL zero_len_idle done=%b value=%0d want 0,7", done, value);
        else passed++;
    endtask

    task automatic test_clamp;
        int busy_cnt = 0;
        launch(5'd1, 8'b00_00_00_00, 4'b0000, 3'd7);
        for (int i = 0; i < 6 && done !== 1'b1; i++) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
        end
        total++;
        if (busy_cnt != 4 || value !== 5'd16 || done !== 1'b1)
            $display("FAIL clamp busy_cycles=%0d value=%0d done=%b want 4,16,1",
                     busy_cnt, value, done);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back;
        launch(5'd1, 8'b00_00_00_00, 4'b0011, 3'd2);
        // new program presented while busy must not disturb the running job
        data = 5'd31; ops = 8'b10_10_10_10; mask = 4'b0001; nsteps = 3'd1;
        start = 1'b1;
        tick();
        total++;
        if (value !== 5'd2 || acc !== 8'd2 || busy !== 1'b1)
            $display("FAIL busy_ignore value=%0d acc=%0d busy=%b want 2,2,1",
                     value, acc, busy);
        else passed++;
        tick();
        total++;
        if (value !== 5'd4 || acc !== 8'd6 || done !== 1'b1)
            $display("FAIL b2b_first value=%0d acc=%0d done=%b want 4,6,1",
                     value, acc, done);
        else passed++;
        tick();
        start = 1'b0;
        total++;
        if ({busy, done, value, acc} !== {1'b1, 1'b0, 5'd31, 8'd0})
            $display("FAIL b2b_load busy=%b done=%b value=%0d acc=%0d want 1,0,31,0",
                     busy, done, value, acc);
        else passed++;
        tick();
        total++;
        if (value !== 5'd15 || acc !== 8'd15 || done !== 1'b1)
            $display("FAIL b2b_second value=%0d acc=%0d done=%b want 15,15,1",
                     value, acc, done);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid;
        launch(5'd3, 8'b00_00_00_00, 4'b1111, 3'd4);
        tick();
        total++;
        if (value !== 5'd6 || busy !== 1'b1)
            $display("FAIL mid_pre value=%0d busy=%b want 6,1", value, busy);
        else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, value, acc} !== 15'd0)
            $display("FAIL mid_reset busy=%b done=%b value=%0d acc=%0d want 0,0,0,0",
                     busy, done, value, acc);
        else passed++;
        #1 rst_n = 1'b1;
        tick();
        launch(5'd5, 8'b00_00_00_01, 4'b0001, 3'd1);
        tick();
        total++;
        if (value !== 5'd20 || acc !== 8'd20 || done !== 1'b1)
            $display("FAIL after_reset value=%0d acc=%0d done=%b want 20,20,1",
                     value, acc, done);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncate();
        test_wrap();
        test_nop_zero();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
